// File: rtl/frame_bank_pkg.sv
// Shared types and constants for the double-buffered frame bank scheduler.
package frame_bank_pkg;

  localparam int BANK_BITS   = 1;
  localparam int FRAME_CNT_W = 16;
  localparam int DROP_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_DRAWING   = 3'd3,
    ST_READY     = 3'd4
  } fb_state_e;

  // Compositor writes only land in VRAM while a pass is actually in flight.
  function automatic logic is_write_window(input fb_state_e st);
    return (st == ST_WAIT_BUSY) || (st == ST_DRAWING);
  endfunction

endpackage

// File: rtl/frame_bank_scheduler_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Count register: synchronous clear wins over increment; hold at full scale.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else if (clr) begin
      q_r <= '0;
    end else if (inc && (q_r != '1)) begin
      q_r <= q_r + WIDTH'(1);
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/frame_bank_scheduler.sv
// Double-buffer scheduler: kicks one compositor pass per frame into the back
// bank and swaps banks only on a vsync that finds the pass complete.
module frame_bank_scheduler
  import frame_bank_pkg::*;
#(
  parameter int VRAM_A_WIDTH  = 16,
  parameter int START_TIMEOUT = 15
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    i_vsync,
  input  logic                    i_draw_busy,
  input  logic [VRAM_A_WIDTH-1:0] i_draw_addr,
  input  logic                    i_draw_we,
  input  logic [VRAM_A_WIDTH-1:0] i_scan_addr,
  output logic                    o_draw_start,
  output logic [VRAM_A_WIDTH:0]   o_wr_addr,
  output logic                    o_wr_en,
  output logic [VRAM_A_WIDTH:0]   o_rd_addr,
  output logic                    o_front_bank,
  output logic [FRAME_CNT_W-1:0]  o_frame_cnt,
  output logic [DROP_CNT_W-1:0]   o_drop_cnt,
  output logic                    o_err
);

  localparam int TMO_W = $clog2(START_TIMEOUT + 1);
  // Counter value seen during the last WAIT_BUSY cycle that may still see busy.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

  fb_state_e              state_r;
  fb_state_e              state_s;
  logic [BANK_BITS-1:0]   front_r;
  logic [FRAME_CNT_W-1:0] frame_cnt_r;
  logic [TMO_W-1:0]       tmo_cnt_r;
  logic                   err_r;
  logic                   draw_start_r;
  logic                   swap_s;
  logic                   drop_inc_s;
  logic                   timeout_s;

  // Next-state decode plus the swap / drop / timeout event strobes.
  always_comb begin
    state_s    = state_r;
    swap_s     = 1'b0;
    drop_inc_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A compositor still busy from before reset is ignored here.
        if (i_vsync) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        drop_inc_s = i_vsync;
        state_s    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        drop_inc_s = i_vsync;
        if (i_draw_busy) begin
          state_s = ST_DRAWING;
        end else if (tmo_cnt_r == TMO_LAST) begin
          // Compositor never started: treat as an empty pass so the
          // display keeps running.
          timeout_s = 1'b1;
          state_s   = ST_READY;
        end else begin
          state_s = ST_WAIT_BUSY;
        end
      end
      ST_DRAWING: begin
        if (i_draw_busy) begin
          drop_inc_s = i_vsync;
          state_s    = ST_DRAWING;
        end else if (i_vsync) begin
          // Pass finished on the very vsync edge: counts as on time.
          swap_s  = 1'b1;
          state_s = ST_START;
        end else begin
          state_s = ST_READY;
        end
      end
      ST_READY: begin
        if (i_vsync) begin
          swap_s  = 1'b1;
          state_s = ST_START;
        end else begin
          state_s = ST_READY;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Start-timeout counter: cleared in START, counts idle WAIT_BUSY cycles.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if (state_r == ST_START) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == ST_WAIT_BUSY) && !i_draw_busy) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Front bank and completed-frame counter advance together on a swap.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      front_r     <= '0;
      frame_cnt_r <= '0;
    end else if (swap_s) begin
      front_r     <= ~front_r;
      frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
    end else begin
      front_r     <= front_r;
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Sticky start-timeout flag and the registered one-cycle start pulse.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      err_r        <= 1'b0;
      draw_start_r <= 1'b0;
    end else begin
      err_r        <= err_r | timeout_s;
      draw_start_r <= (state_s == ST_START);
    end
  end

  sat_counter #(
    .WIDTH (DROP_CNT_W)
  ) u_drop_cnt (
    .CLK (CLK),
    .rst (rst),
    .clr (1'b0),
    .inc (drop_inc_s),
    .q   (o_drop_cnt)
  );

  assign o_wr_addr    = {~front_r, i_draw_addr};
  assign o_rd_addr    = {front_r, i_scan_addr};
  assign o_wr_en      = i_draw_we & is_write_window(state_r);
  assign o_front_bank = front_r;
  assign o_frame_cnt  = frame_cnt_r;
  assign o_err        = err_r;
  assign o_draw_start = draw_start_r;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler: a per-cycle vector table followed
// by hand-written multi-cycle sequences.
module tb_frame_bank_scheduler;

  logic        CLK;
  logic        rst;
  logic        i_vsync;
  logic        i_draw_busy;
  logic [15:0] i_draw_addr;
  logic        i_draw_we;
  logic [15:0] i_scan_addr;
  logic        o_draw_start;
  logic [16:0] o_wr_addr;
  logic        o_wr_en;
  logic [16:0] o_rd_addr;
  logic        o_front_bank;
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_drop_cnt;
  logic        o_err;

  int total;
  int bad;

  frame_bank_scheduler #(
    .VRAM_A_WIDTH  (16),
    .START_TIMEOUT (15)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .i_vsync      (i_vsync),
    .i_draw_busy  (i_draw_busy),
    .i_draw_addr  (i_draw_addr),
    .i_draw_we    (i_draw_we),
    .i_scan_addr  (i_scan_addr),
    .o_draw_start (o_draw_start),
    .o_wr_addr    (o_wr_addr),
    .o_wr_en      (o_wr_en),
    .o_rd_addr    (o_rd_addr),
    .o_front_bank (o_front_bank),
    .o_frame_cnt  (o_frame_cnt),
    .o_drop_cnt   (o_drop_cnt),
    .o_err        (o_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        vs;
    logic        busy;
    logic        we;
    logic [15:0] da;
    logic [15:0] sa;
    logic        st;
    logic        fr;
    logic        wen;
    logic [16:0] wa;
    logic [16:0] ra;
    logic [15:0] fc;
    logic [7:0]  dc;
    logic        er;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic vsync_pulse();
    i_vsync = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    i_vsync = 1'b0;
  endtask

  task automatic do_reset();
    i_vsync     = 1'b0;
    i_draw_busy = 1'b0;
    i_draw_we   = 1'b0;
    rst         = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    i_vsync     = 1'b0;
    i_draw_busy = 1'b0;
    i_draw_we   = 1'b1;
    i_draw_addr = 16'h0000;
    i_scan_addr = 16'h0000;

    //        vs    busy  we    da        sa        st    fr    wen   wa         ra         fc     dc    er
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 16'h0012, 16'h0034, 1'b0, 1'b0, 1'b0, 17'h10012, 17'h00034, 16'd0, 8'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h0012, 16'h0034, 1'b0, 1'b0, 1'b0, 17'h10012, 17'h00034, 16'd0, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'h0012, 16'h0034, 1'b1, 1'b0, 1'b0, 17'h10012, 17'h00034, 16'd0, 8'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h00AB, 16'h0034, 1'b0, 1'b0, 1'b1, 17'h100AB, 17'h00034, 16'd0, 8'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 17'h1FFFF, 17'h0FFFF, 16'd0, 8'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 17'h1FFFF, 17'h0FFFF, 16'd0, 8'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b1, 17'h10100, 17'h00200, 16'd0, 8'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, 17'h10100, 17'h00200, 16'd0, 8'd1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, 17'h10100, 17'h00200, 16'd0, 8'd1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b0, 17'h01234, 17'h15678, 16'd1, 8'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 16'h0001, 16'h5678, 1'b0, 1'b1, 1'b1, 17'h00001, 17'h15678, 16'd1, 8'd1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h0001, 16'h5678, 1'b0, 1'b1, 1'b0, 17'h00001, 17'h15678, 16'd1, 8'd1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 16'h0002, 16'h0003, 1'b1, 1'b0, 1'b0, 17'h10002, 17'h00003, 16'd2, 8'd1, 1'b0};

    // Reset state, with a write attempted while in reset.
    @(negedge CLK);
    check("rst_start", {31'd0, o_draw_start}, 32'd0);
    check("rst_front", {31'd0, o_front_bank}, 32'd0);
    check("rst_fcnt",  {16'd0, o_frame_cnt},  32'd0);
    check("rst_dcnt",  {24'd0, o_drop_cnt},   32'd0);
    check("rst_err",   {31'd0, o_err},        32'd0);
    check("rst_wen",   {31'd0, o_wr_en},      32'd0);
    rst = 1'b0;

    // Vector table: expected values describe the cycle in which the inputs are applied.
    for (int i = 0; i < 13; i++) begin
      i_vsync     = tbl[i].vs;
      i_draw_busy = tbl[i].busy;
      i_draw_we   = tbl[i].we;
      i_draw_addr = tbl[i].da;
      i_scan_addr = tbl[i].sa;
      #1;
      check($sformatf("v%0d_start", i), {31'd0, o_draw_start}, {31'd0, tbl[i].st});
      check($sformatf("v%0d_front", i), {31'd0, o_front_bank}, {31'd0, tbl[i].fr});
      check($sformatf("v%0d_wen", i),   {31'd0, o_wr_en},      {31'd0, tbl[i].wen});
      check($sformatf("v%0d_waddr", i), {15'd0, o_wr_addr},    {15'd0, tbl[i].wa});
      check($sformatf("v%0d_raddr", i), {15'd0, o_rd_addr},    {15'd0, tbl[i].ra});
      check($sformatf("v%0d_fcnt", i),  {16'd0, o_frame_cnt},  {16'd0, tbl[i].fc});
      check($sformatf("v%0d_dcnt", i),  {24'd0, o_drop_cnt},   {24'd0, tbl[i].dc});
      check($sformatf("v%0d_err", i),   {31'd0, o_err},        {31'd0, tbl[i].er});
      @(posedge CLK);
      @(negedge CLK);
    end

    // Long draw: start one cycle after each vsync, swap on the second vsync.
    do_reset();
    vsync_pulse();
    check("a_start1", {31'd0, o_draw_start}, 32'd1);
    i_draw_busy = 1'b1;
    cycles(1);
    check("a_start1_end", {31'd0, o_draw_start}, 32'd0);
    cycles(100);
    check("a_front_hold", {31'd0, o_front_bank}, 32'd0);
    i_draw_busy = 1'b0;
    cycles(1);
    vsync_pulse();
    check("a_front_swap", {31'd0, o_front_bank}, 32'd1);
    check("a_fcnt",       {16'd0, o_frame_cnt},  32'd1);
    check("a_start2",     {31'd0, o_draw_start}, 32'd1);
    cycles(1);
    check("a_start2_end", {31'd0, o_draw_start}, 32'd0);

    // Busy over three vsync periods: two drops, swap only after busy falls.
    do_reset();
    vsync_pulse();
    i_draw_busy = 1'b1;
    cycles(20);
    vsync_pulse();
    cycles(20);
    vsync_pulse();
    cycles(20);
    check("b_dcnt",  {24'd0, o_drop_cnt},   32'd2);
    check("b_front", {31'd0, o_front_bank}, 32'd0);
    check("b_fcnt",  {16'd0, o_frame_cnt},  32'd0);
    i_draw_busy = 1'b0;
    cycles(2);
    check("b_front_ready", {31'd0, o_front_bank}, 32'd0);
    vsync_pulse();
    check("b_front_swap", {31'd0, o_front_bank}, 32'd1);
    check("b_fcnt_swap",  {16'd0, o_frame_cnt},  32'd1);
    check("b_dcnt_swap",  {24'd0, o_drop_cnt},   32'd2);
    check("b_start",      {31'd0, o_draw_start}, 32'd1);

    // Start timeout: busy never rises, err on the edge after the 15th wait cycle.
    do_reset();
    vsync_pulse();
    cycles(1);
    cycles(14);
    check("c_err_before", {31'd0, o_err}, 32'd0);
    i_draw_we = 1'b1;
    #1;
    check("c_wen_wait", {31'd0, o_wr_en}, 32'd1);
    cycles(1);
    check("c_err_set",   {31'd0, o_err},   32'd1);
    check("c_wen_ready", {31'd0, o_wr_en}, 32'd0);
    check("c_fcnt_pre",  {16'd0, o_frame_cnt}, 32'd0);
    vsync_pulse();
    check("c_front", {31'd0, o_front_bank}, 32'd1);
    check("c_fcnt",  {16'd0, o_frame_cnt},  32'd1);
    check("c_start", {31'd0, o_draw_start}, 32'd1);
    check("c_err_sticky", {31'd0, o_err},   32'd1);
    i_draw_we = 1'b0;

    // Busy arriving on the last allowed wait cycle is not a timeout.
    do_reset();
    vsync_pulse();
    cycles(15);
    i_draw_busy = 1'b1;
    i_draw_we   = 1'b1;
    cycles(1);
    check("c2_err",     {31'd0, o_err},   32'd0);
    check("c2_wen_drw", {31'd0, o_wr_en}, 32'd1);
    cycles(20);
    check("c2_err_late", {31'd0, o_err},  32'd0);
    i_draw_we   = 1'b0;

    // Drop counter saturation, then frame counter wrap on a coincident swap.
    do_reset();
    vsync_pulse();
    i_draw_busy = 1'b1;
    cycles(2);
    for (int k = 0; k < 254; k++) begin
      vsync_pulse();
      cycles(1);
    end
    check("d_dcnt_254", {24'd0, o_drop_cnt}, 32'd254);
    for (int k = 0; k < 46; k++) begin
      vsync_pulse();
      cycles(1);
    end
    check("d_dcnt_sat", {24'd0, o_drop_cnt},   32'd255);
    check("d_front",    {31'd0, o_front_bank}, 32'd0);
    force dut.frame_cnt_r = 16'hFFFF;
    cycles(1);
    release dut.frame_cnt_r;
    cycles(1);
    check("d_fcnt_max", {16'd0, o_frame_cnt}, 32'h0000FFFF);
    i_draw_busy = 1'b0;
    vsync_pulse();
    check("d_fcnt_wrap",  {16'd0, o_frame_cnt},  32'd0);
    check("d_front_swap", {31'd0, o_front_bank}, 32'd1);
    check("d_dcnt_hold",  {24'd0, o_drop_cnt},   32'd255);
    check("d_start",      {31'd0, o_draw_start}, 32'd1);

    // Reset mid-draw: writes blocked at once and until a vsync restarts.
    i_draw_busy = 1'b1;
    i_draw_we   = 1'b1;
    cycles(2);
    check("e_wen_drw", {31'd0, o_wr_en}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("e_wen_rst",   {31'd0, o_wr_en},      32'd0);
    check("e_front_rst", {31'd0, o_front_bank}, 32'd0);
    check("e_fcnt_rst",  {16'd0, o_frame_cnt},  32'd0);
    check("e_dcnt_rst",  {24'd0, o_drop_cnt},   32'd0);
    check("e_start_rst", {31'd0, o_draw_start}, 32'd0);
    @(negedge CLK);
    rst = 1'b0;
    cycles(3);
    check("e_wen_idle",   {31'd0, o_wr_en},      32'd0);
    check("e_start_idle", {31'd0, o_draw_start}, 32'd0);
    vsync_pulse();
    check("e_start", {31'd0, o_draw_start}, 32'd1);
    check("e_wen_start", {31'd0, o_wr_en},  32'd0);
    cycles(1);
    check("e_wen_wait", {31'd0, o_wr_en}, 32'd1);
    check("e_waddr", {15'd0, o_wr_addr}, {15'd0, 1'b1, i_draw_addr});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_bank_scheduler.md
# frame_bank_scheduler

Double-buffer scheduler between the layer compositor and VRAM/scanout. Each vertical blank it kicks one compositor pass into the back bank, waits for it to finish, then swaps banks on the next vertical blank so scanout never shows a partly drawn frame. Late frames are counted, never torn. A missing compositor start is flagged.

## Interface
Parameters:
- VRAM_A_WIDTH, 16, per-bank VRAM address width (320x180 fits).
- START_TIMEOUT, 15, cycles allowed after o_draw_start for i_draw_busy to rise.

Ports:
- CLK  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i_vsync  in  1  one-cycle pulse per frame (pix_stb & screenend).
- i_draw_busy  in  1  compositor "layer drawing" level.
- i_draw_addr  in  VRAM_A_WIDTH  compositor screen address.
- i_draw_we  in  1  compositor write enable.
- i_scan_addr  in  VRAM_A_WIDTH  scanout read address.
- o_draw_start  out  1  one-cycle pulse, compositor frame reset.
- o_wr_addr  out  VRAM_A_WIDTH+1  {back_bank, i_draw_addr}.
- o_wr_en  out  1  gated write enable.
- o_rd_addr  out  VRAM_A_WIDTH+1  {front_bank, i_scan_addr}.
- o_front_bank  out  1  bank currently scanned out.
- o_frame_cnt  out  16  completed swaps, wraps at 0xFFFF->0.
- o_drop_cnt  out  8  vsyncs that found drawing unfinished, saturates at 255.
- o_err  out  1  sticky start-timeout flag.

## Operation
- States: IDLE, START, WAIT_BUSY, DRAWING, READY.
- IDLE: entered on reset. First i_vsync -> START. No swap and no frame_cnt change.
- START: o_draw_start=1 for exactly this cycle. Load timeout counter. Next state is WAIT_BUSY.
- WAIT_BUSY: i_draw_busy=1 -> DRAWING. If the counter reaches START_TIMEOUT with busy still low -> set o_err and go to READY, treating the pass as an empty draw.
- DRAWING: i_draw_busy=0 -> READY.
- READY: i_vsync -> toggle front bank, increment o_frame_cnt, go to START.
- i_vsync in START, WAIT_BUSY or DRAWING: o_drop_cnt+1 (saturating). No swap and the state is unchanged. The pass continues and the swap waits for a later vsync.
- Simultaneous events in DRAWING: i_draw_busy falling and i_vsync in the same cycle count as on time. Swap, frame_cnt+1, go directly to START. No drop.
- o_wr_en = i_draw_we & (state is WAIT_BUSY or DRAWING). Writes in any other state are discarded.
- back_bank is always ~front_bank. Write and read address muxing is combinational.
- rst asserted mid-pass: all state clears immediately. A compositor still busy after reset is ignored until the first vsync.

## Timing
- Reset values: state IDLE, o_front_bank 0, o_draw_start 0, o_frame_cnt 0, o_drop_cnt 0, o_err 0. Outputs become valid once the first i_vsync is sampled.
- Bank swap: o_front_bank changes on the edge that samples i_vsync in READY.
- o_draw_start is high in the cycle after that edge, giving 1 cycle of vsync->start latency.
- i_vsync sampled in IDLE also gives o_draw_start one cycle later.
- Timeout: the START_TIMEOUT-th cycle spent in WAIT_BUSY without busy is the last one. The next edge sets o_err and enters READY.
- o_wr_addr, o_wr_en and o_rd_addr are combinational from inputs and registered bank/state: zero latency.
- All other outputs are registered.

## Structure
- Shared package `frame_bank_pkg`:
  - state enum encodings (IDLE, START, WAIT_BUSY, DRAWING, READY);
  - the BANK_BITS=1 constant;
  - counter width constants FRAME_CNT_W=16 and DROP_CNT_W=8.
- One sub-module `sat_counter`, parameter WIDTH, with ports inc/clr/q; saturates at all-ones. Used for o_drop_cnt.
- Timeout and frame counters stay inline.

## Test plan
- Reset, vsync, busy high for 100 cycles then low, vsync -> o_draw_start pulses at cycles 1 and 1 after each vsync; o_front_bank 0->1 at the second vsync; o_frame_cnt=1.
- Busy held for 3 vsync periods -> o_drop_cnt=2; the swap happens only at the first vsync after busy falls; o_front_bank stays constant while drawing.
- Busy never rises after o_draw_start -> o_err=1 after 15 cycles; state READY; the next vsync swaps, frame_cnt+1.
- Busy fall coincident with vsync -> swap in that cycle, o_drop_cnt unchanged, o_draw_start next cycle.
- 300 late vsyncs -> o_drop_cnt=255 and holds. Also force o_frame_cnt wrap: 0xFFFF->0 on the next swap.
- rst pulsed mid-DRAWING with i_draw_we=1 -> o_wr_en=0 immediately, all counters 0, o_front_bank 0. Writes stay blocked until a vsync restarts the sequence.
